// File: rtl/cic_pkg.sv
// Shared helpers for the CIC filter family (integrators, decimating combs, interpolator).
// Parameter legality and counter sizing live here so every CIC block agrees on them.
package cic_pkg;

    function automatic bit cic_params_ok(input int win, input int wout, input int stages,
                                         input int decim, input int diff_delay);
        return (wout >= 1) && (wout <= win) && (stages >= 1) && (decim >= 1) &&
               ((diff_delay == 1) || (diff_delay == 2));
    endfunction

    // A ratio of 1 still needs a one-bit counter so the port widths stay legal.
    function automatic int cic_cnt_width(input int decim);
        return (decim > 1) ? $clog2(decim) : 1;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x delayed by DIFF_DELAY kept samples, modular arithmetic.
// Output data and strobe are registered, giving exactly one clock of latency per stage.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIFF_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic                    str_i,
    output logic signed [WIDTH-1:0] y_o,
    output logic                    str_o
);
    typedef logic signed [WIDTH-1:0] comb_word_t;

    comb_word_t d_q [DIFF_DELAY];
    comb_word_t y_q, y_d;
    logic       str_q;

    // Wrap on overflow is intentional: CIC correctness relies on modulo-2^WIDTH arithmetic.
    assign y_d = x_i - d_q[DIFF_DELAY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIFF_DELAY; i++) d_q[i] <= '0;
            y_q   <= '0;
            str_q <= 1'b0;
        end else begin
            str_q <= str_i;
            if (str_i) begin
                y_q    <= y_d;
                d_q[0] <= x_i;
                for (int i = 1; i < DIFF_DELAY; i++) d_q[i] <= d_q[i-1];
            end
        end
    end

    assign y_o   = y_q;
    assign str_o = str_q;

endmodule

// File: rtl/cic_comb_decimator.sv
// Decimating comb section of a Hogenauer CIC: keeps every DECIM-th integrator sample,
// runs STAGES differentiators on it and emits the MSB slice with a one-cycle strobe.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH_INP = 16,
    parameter int DATA_WIDTH_OUT = 16,
    parameter int STAGES         = 3,
    parameter int DECIM          = 8,
    parameter int DIFF_DELAY     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
    input  logic                             inp_samp_str,
    output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data,
    output logic                             out_samp_str
);
    localparam int CW        = cic_cnt_width(DECIM);
    localparam bit PARAMS_OK = cic_params_ok(DATA_WIDTH_INP, DATA_WIDTH_OUT, STAGES,
                                             DECIM, DIFF_DELAY);

    typedef logic signed [DATA_WIDTH_INP-1:0] comb_word_t;

    logic [CW-1:0] phase_q, phase_d;
    logic          keep;
    comb_word_t    dec_data_q;
    logic          dec_str_q;

    comb_word_t stg_data [STAGES+1];
    logic       vld_pipe [STAGES+1];

    always_ff @(posedge clk) begin
        assert (PARAMS_OK);
    end

    always_comb begin
        keep    = inp_samp_str && (phase_q == CW'(DECIM - 1));
        phase_d = phase_q;
        if (inp_samp_str) phase_d = keep ? '0 : phase_q + 1'b1;
    end

    // Decimation register: the kept sample is held until the next kept one.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            dec_data_q <= '0;
            dec_str_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            dec_str_q <= keep;
            if (keep) dec_data_q <= inp_samp_data;
        end
    end

    assign stg_data[0] = dec_data_q;
    assign vld_pipe[0] = dec_str_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        cic_comb_stage #(
            .WIDTH      (DATA_WIDTH_INP),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .x_i   (stg_data[k]),
            .str_i (vld_pipe[k]),
            .y_o   (stg_data[k+1]),
            .str_o (vld_pipe[k+1])
        );
    end

    // Last stage only updates on its strobe, so the slice holds between outputs.
    assign out_samp_data = stg_data[STAGES][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
    assign out_samp_str  = vld_pipe[STAGES];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: directed per-cycle tables on small configurations plus a
// randomized run on a wider configuration against a binomial-difference reference model.
module tb_cic_comb_decimator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // main: 16/12 bits, 3 stages, R=3, M=2
    localparam int MS = 3;
    localparam int MD = 3;
    localparam int MM = 2;
    logic [15:0] m_data = '0;  logic m_str = 1'b0;  logic [11:0] m_out;  logic m_ostr;
    // a: 8/8, N=1, R=4, M=1   b: 8/8, N=3, R=1, M=1   c: 8/8, N=1, R=2, M=2   d: 16/8, N=1, R=2, M=1
    logic [7:0]  a_data = '0; logic a_str = 1'b0; logic [7:0] a_out; logic a_ostr;
    logic [7:0]  b_data = '0; logic b_str = 1'b0; logic [7:0] b_out; logic b_ostr;
    logic [7:0]  c_data = '0; logic c_str = 1'b0; logic [7:0] c_out; logic c_ostr;
    logic [15:0] d_data = '0; logic d_str = 1'b0; logic [7:0] d_out; logic d_ostr;

    cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(12), .STAGES(MS), .DECIM(MD), .DIFF_DELAY(MM))
        u_main (.clk(clk), .reset(reset), .inp_samp_data(m_data), .inp_samp_str(m_str),
                .out_samp_data(m_out), .out_samp_str(m_ostr));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DECIM(4), .DIFF_DELAY(1))
        u_a (.clk(clk), .reset(reset), .inp_samp_data(a_data), .inp_samp_str(a_str),
             .out_samp_data(a_out), .out_samp_str(a_ostr));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(3), .DECIM(1), .DIFF_DELAY(1))
        u_b (.clk(clk), .reset(reset), .inp_samp_data(b_data), .inp_samp_str(b_str),
             .out_samp_data(b_out), .out_samp_str(b_ostr));
    cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DECIM(2), .DIFF_DELAY(2))
        u_c (.clk(clk), .reset(reset), .inp_samp_data(c_data), .inp_samp_str(c_str),
             .out_samp_data(c_out), .out_samp_str(c_ostr));
    cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(8), .STAGES(1), .DECIM(2), .DIFF_DELAY(1))
        u_d (.clk(clk), .reset(reset), .inp_samp_data(d_data), .inp_samp_str(d_str),
             .out_samp_data(d_out), .out_samp_str(d_ostr));

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- directed tables ----------------
    typedef struct {
        bit          seg;
        int          dut;
        bit          rst;
        bit          str;
        logic [15:0] d;
        bit          es;
        logic [15:0] ed;
    } vec_t;
    vec_t vecs[$];

    int          rd   [11] = '{10, 20, 30, 40, 99, 50, 60, 70, 80, 0, 0};
    logic [15:0] bexp [14] = '{0, 0, 0, 0, 16'h01, 16'hFD, 16'h03, 16'hFF, 0, 0, 0, 0, 0, 0};
    logic [15:0] ddat [6]  = '{16'h1111, 16'h1234, 16'h0F0F, 16'h2468, 16'h7777, 16'h369C};

    function automatic void add(input bit seg, input int dut, input bit rst, input bit str,
                                input logic [15:0] d, input bit es, input logic [15:0] ed);
        vec_t v;
        v.seg = seg; v.dut = dut; v.rst = rst; v.str = str; v.d = d; v.es = es; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        a_str = 1'b0; b_str = 1'b0; c_str = 1'b0; d_str = 1'b0; m_str = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset a str", 32'(a_ostr), 0); chk("reset a data", 32'(a_out), 0);
        chk("reset b str", 32'(b_ostr), 0); chk("reset b data", 32'(b_out), 0);
        chk("reset c str", 32'(c_ostr), 0); chk("reset c data", 32'(c_out), 0);
        chk("reset d str", 32'(d_ostr), 0); chk("reset d data", 32'(d_out), 0);
        chk("reset main str", 32'(m_ostr), 0); chk("reset main data", 32'(m_out), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_row(input int idx, input vec_t v);
        logic [15:0] dv;
        logic        act_s;
        logic [15:0] act_d;
        dv = v.d;
        reset = v.rst;
        idle_inputs();
        case (v.dut)
            0: begin a_str = v.str; a_data = dv[7:0]; end
            1: begin b_str = v.str; b_data = dv[7:0]; end
            2: begin c_str = v.str; c_data = dv[7:0]; end
            default: begin d_str = v.str; d_data = dv; end
        endcase
        @(negedge clk);
        case (v.dut)
            0: begin act_s = a_ostr; act_d = 16'(a_out); end
            1: begin act_s = b_ostr; act_d = 16'(b_out); end
            2: begin act_s = c_ostr; act_d = 16'(c_out); end
            default: begin act_s = d_ostr; act_d = 16'(d_out); end
        endcase
        chk($sformatf("dut%0d row%0d strobe", v.dut, idx), 32'(act_s), 32'(v.es));
        chk($sformatf("dut%0d row%0d data", v.dut, idx), 32'(act_d), 32'(v.ed));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model for the random run ----------------
    typedef struct { int due; logic [11:0] val; } mexp_t;
    mexp_t       mexp[$];
    logic [15:0] hist[$];
    int          nstr = 0;
    logic [11:0] last = '0;
    bit          mon_en = 1'b0;

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
        return r;
    endfunction

    // N-th order M-lag difference of the kept sequence, zeros before reset: sum (-1)^j C(N,j) x[n-jM]
    function automatic logic [15:0] ref_y();
        longint acc = 0;
        int     n = hist.size() - 1;
        for (int j = 0; j <= MS; j++) begin
            int     idx = n - j * MM;
            longint c = binom(MS, j);
            if (idx >= 0) acc += (((j % 2) != 0) ? -c : c) * longint'(hist[idx]);
        end
        return acc[15:0];
    endfunction

    task automatic main_drive(input bit s, input logic [15:0] d);
        logic [15:0] y;
        mexp_t       e;
        m_str = s; m_data = d;
        if (s) begin
            if ((nstr % MD) == MD - 1) begin
                hist.push_back(d);
                y = ref_y();
                e.due = cyc + MS + 1;
                e.val = y[15:4];
                mexp.push_back(e);
            end
            nstr++;
        end
        @(posedge clk); #1;
    endtask

    task automatic main_reset();
        logic [15:0] r;
        r = 16'($urandom);
        reset = 1'b1; m_str = 1'b1; m_data = r;
        @(posedge clk); #1;
        reset = 1'b0; m_str = 1'b0;
        mexp.delete(); hist.delete(); nstr = 0; last = '0;
    endtask

    always @(negedge clk) begin : mon
        mexp_t e;
        if (mon_en) begin
            if (m_ostr) begin
                if (mexp.size() == 0) begin
                    chk("main spurious strobe", 1, 0);
                end else begin
                    e = mexp.pop_front();
                    chk("main strobe cycle", 32'(cyc), 32'(e.due));
                    chk("main data", 32'(m_out), 32'(e.val));
                    last = e.val;
                end
            end else begin
                chk("main hold", 32'(m_out), 32'(last));
                if (mexp.size() > 0 && mexp[0].due <= cyc) begin
                    chk("main missing strobe", 0, 1);
                    void'(mexp.pop_front());
                end
            end
        end
    end

    initial begin
        // A: count 0..15, R=4 -> kept 3,7,11,15 -> 3,4,4,4, two cycles after each kept input
        for (int i = 0; i < 18; i++)
            add(i == 0, 0, 0, i < 16, (i < 16) ? 16'(i) : 16'h00FF, i inside {5, 9, 13, 17},
                (i < 5) ? 16'h0 : (i < 9) ? 16'h3 : 16'h4);
        // A wrap: 248..255,0..7 -> kept -5,-1,3,7 -> 0xFB then 4,4,4
        for (int i = 0; i < 18; i++)
            add(i == 0, 0, 0, i < 16, 16'((248 + i) % 256), i inside {5, 9, 13, 17},
                (i < 5) ? 16'h0 : (i < 9) ? 16'h00FB : 16'h4);
        // A reset mid-stream: kept 40 discarded; strobe with reset ignored; next kept is 80
        for (int i = 0; i < 11; i++)
            add(i == 0, 0, i == 4, i < 9, 16'(rd[i]), i == 10, (i == 10) ? 16'h50 : 16'h0);
        // B: impulse through 3 stages, R=1 -> 1,-3,3,-1,0...
        for (int i = 0; i < 14; i++)
            add(i == 0, 1, 0, i < 10, (i == 0) ? 16'h1 : 16'h0, i >= 4, bexp[i]);
        // C: M=2, R=2, constant 10 -> 10,10,0,0,0
        for (int i = 0; i < 12; i++)
            add(i == 0, 2, 0, i < 10, 16'd10, i inside {3, 5, 7, 9, 11},
                (i >= 3 && i < 7) ? 16'd10 : 16'h0);
        // D: 16->8 truncation, strobe every 3rd cycle, differences of 0x1234 -> 0x12
        for (int i = 0; i < 18; i++)
            add(i == 0, 3, 0, (i % 3) == 0, ((i % 3) == 0) ? ddat[i / 3] : 16'hABCD,
                i inside {5, 11, 17}, (i >= 5) ? 16'h12 : 16'h0);

        foreach (vecs[i]) begin
            if (vecs[i].seg) do_reset();
            run_row(i, vecs[i]);
        end

        // Randomized run on the main configuration
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 200; i++) main_drive(1'b1, 16'($urandom));
        for (int i = 0; i < 200; i++) begin
            if (i == 100) main_reset();
            main_drive(1'($urandom_range(0, 1)), 16'($urandom));
        end
        for (int i = 0; i < 200; i++) main_drive((i % 3) == 0, 16'($urandom));
        for (int i = 0; i < MS + 4; i++) main_drive(1'b0, 16'h0);
        mon_en = 1'b0;
        chk("main drained", 32'(mexp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
